// File: rtl/onion_pwm_fade_engine.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | onion_pwm_fade_engine : Wishbone PWM bank with hardware duty-cycle fading   |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module onion_pwm_fade_engine #(
  parameter int          NUM_CH       = 4,
  parameter int          ADDRWIDTH    = 10,
  parameter logic [31:0] DEF_RD_VALUE = 32'hDEF_FAB_AC
) (
  input  logic              WBs_CLK_i,
  input  logic              WBs_RST_n_i,
  input  logic [16:0]       WBs_ADR_i,
  input  logic              WBs_CYC_i,
  input  logic              WBs_STB_i,
  input  logic              WBs_WE_i,
  input  logic [3:0]        WBs_BYTE_STB_i,
  input  logic [31:0]       WBs_DAT_i,
  output logic [31:0]       WBs_DAT_o,
  output logic              WBs_ACK_o,
  output logic [NUM_CH-1:0] PWM_o
);

  localparam int WW = ADDRWIDTH - 2;

  logic [WW-1:0]         word_idx;
  logic                  req, wr_req, ctrl_wr, status_wr;
  logic                  ack_q;
  logic [31:0]           dat_q, rdata;
  logic                  en_q;
  logic [7:0]            prescale_q, presc_q, cnt_q;
  logic                  tick, period_end;
  logic [NUM_CH-1:0]     done_q, done_d, done_set, w1c, busy, pwm_d, pwm_q;
  logic [8*NUM_CH-1:0]   target_all, duty_all, interval_all;
  logic                  unused_bits;

  assign word_idx   = WBs_ADR_i[ADDRWIDTH-1:2];
  assign req        = WBs_CYC_i & WBs_STB_i & ~ack_q;
  assign wr_req     = req & WBs_WE_i;
  assign ctrl_wr    = wr_req && (word_idx == WW'(0));
  assign status_wr  = wr_req && (word_idx == WW'(1));
  assign unused_bits = ^{WBs_ADR_i[16:ADDRWIDTH], WBs_ADR_i[1:0],
                         WBs_DAT_i[31:24], WBs_BYTE_STB_i[3]};

  assign tick       = (presc_q == prescale_q);
  assign period_end = en_q & tick & (cnt_q == 8'hFF);

  assign w1c    = (status_wr & WBs_BYTE_STB_i[2]) ? WBs_DAT_i[16 +: NUM_CH] : '0;
  // A hardware set on the same edge as a W1C must survive.
  assign done_d = (done_q & ~w1c) | done_set;

  always_comb begin
    rdata = DEF_RD_VALUE;
    if (word_idx == WW'(0)) begin
      rdata = {16'h0, prescale_q, 7'h0, en_q};
    end else if (word_idx == WW'(1)) begin
      rdata = '0;
      rdata[NUM_CH-1:0]     = busy;
      rdata[16 +: NUM_CH]   = done_q;
    end
    for (int i = 0; i < NUM_CH; i++) begin
      if (word_idx == WW'(4 + i)) begin
        rdata = {8'h0, interval_all[8*i +: 8], duty_all[8*i +: 8], target_all[8*i +: 8]};
      end
    end
  end

  always_ff @(posedge WBs_CLK_i or negedge WBs_RST_n_i) begin
    if (!WBs_RST_n_i) begin
      ack_q      <= 1'b0;
      dat_q      <= '0;
      en_q       <= 1'b0;
      prescale_q <= '0;
      presc_q    <= '0;
      cnt_q      <= '0;
      done_q     <= '0;
      pwm_q      <= '0;
    end else begin
      ack_q  <= req;
      dat_q  <= (req & ~WBs_WE_i) ? rdata : '0;
      done_q <= done_d;
      pwm_q  <= pwm_d;
      if (ctrl_wr && WBs_BYTE_STB_i[0]) en_q       <= WBs_DAT_i[0];
      if (ctrl_wr && WBs_BYTE_STB_i[1]) prescale_q <= WBs_DAT_i[15:8];
      // Disabled timebase parks at zero so re-enable starts a fresh period.
      if (!en_q) begin
        presc_q <= '0;
        cnt_q   <= '0;
      end else begin
        presc_q <= tick ? 8'h00 : presc_q + 8'd1;
        if (tick) cnt_q <= cnt_q + 8'd1;
      end
    end
  end

  assign WBs_ACK_o = ack_q;
  assign WBs_DAT_o = dat_q;
  assign PWM_o     = pwm_q;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [7:0] target_q, duty_q, duty_d, interval_q, ivcnt_q, ivcnt_d, step_val;
    logic       cfg_wr, set_done;

    assign cfg_wr   = wr_req && (word_idx == WW'(4 + i));
    assign busy[i]  = (duty_q != target_q);
    assign step_val = (duty_q < target_q) ? duty_q + 8'd1 : duty_q - 8'd1;

    always_comb begin
      duty_d   = duty_q;
      ivcnt_d  = ivcnt_q;
      set_done = 1'b0;
      if (period_end) begin
        if (!busy[i]) begin
          ivcnt_d = '0;
        end else if (interval_q == 8'h00) begin
          duty_d   = target_q;
          ivcnt_d  = '0;
          set_done = 1'b1;
        end else if (ivcnt_q == interval_q - 8'd1) begin
          duty_d   = step_val;
          ivcnt_d  = '0;
          set_done = (step_val == target_q);
        end else begin
          ivcnt_d = ivcnt_q + 8'd1;
        end
      end
    end

    always_ff @(posedge WBs_CLK_i or negedge WBs_RST_n_i) begin
      if (!WBs_RST_n_i) begin
        target_q   <= '0;
        interval_q <= '0;
        duty_q     <= '0;
        ivcnt_q    <= '0;
      end else begin
        if (cfg_wr && WBs_BYTE_STB_i[0]) target_q   <= WBs_DAT_i[7:0];
        if (cfg_wr && WBs_BYTE_STB_i[2]) interval_q <= WBs_DAT_i[23:16];
        duty_q  <= duty_d;
        ivcnt_q <= ivcnt_d;
      end
    end

    assign done_set[i]              = set_done;
    assign pwm_d[i]                 = en_q && (cnt_q < duty_q);
    assign target_all[8*i +: 8]     = target_q;
    assign duty_all[8*i +: 8]       = duty_q;
    assign interval_all[8*i +: 8]   = interval_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_onion_pwm_fade_engine.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_onion_pwm_fade_engine : scoreboard bench for the PWM fade engine         |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_onion_pwm_fade_engine;

  localparam int          NUM_CH = 4;
  localparam logic [31:0] DEF    = 32'hDEF_FAB_AC;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [16:0]       adr_i = '0;
  logic              cyc_i = 1'b0, stb_i = 1'b0, we_i = 1'b0;
  logic [3:0]        be_i = '0;
  logic [31:0]       dat_i = '0;
  logic [31:0]       dat_o;
  logic              ack_o;
  logic [NUM_CH-1:0] pwm_o;

  onion_pwm_fade_engine #(.NUM_CH(NUM_CH), .ADDRWIDTH(10), .DEF_RD_VALUE(DEF)) dut (
    .WBs_CLK_i     (clk),
    .WBs_RST_n_i   (rst_n),
    .WBs_ADR_i     (adr_i),
    .WBs_CYC_i     (cyc_i),
    .WBs_STB_i     (stb_i),
    .WBs_WE_i      (we_i),
    .WBs_BYTE_STB_i(be_i),
    .WBs_DAT_i     (dat_i),
    .WBs_DAT_o     (dat_o),
    .WBs_ACK_o     (ack_o),
    .PWM_o         (pwm_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          chk;
    logic [31:0] expv;
    logic [31:0] mask;
    string       nm;
  } sb_t;

  sb_t sbq[$];
  int  n_checks = 0, n_pass = 0;
  int  cyc_cnt = 0, last_ack_cyc = 0;
  int  pwm_cnt[NUM_CH];

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic check(input bit ok, input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, expv);
  endtask

  // Monitor: every read ACK pops one expectation.
  initial begin : monitor
    sb_t  e;
    logic prev_ack;
    prev_ack = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (ack_o) begin
        check(!prev_ack, "ack_single_cycle", {31'b0, prev_ack}, 32'h0);
        if (!we_i) begin
          if (sbq.size() == 0) begin
            check(1'b0, "unexpected_read_ack", dat_o, 32'h0);
          end else begin
            e = sbq.pop_front();
            if (e.chk) check((dat_o & e.mask) == (e.expv & e.mask), e.nm, dat_o & e.mask, e.expv & e.mask);
          end
        end
      end
      prev_ack = ack_o;
    end
  end

  task automatic bus(input bit we, input logic [16:0] a, input logic [3:0] be,
                     input logic [31:0] dat, output logic [31:0] d);
    int n;
    n = 0;
    @(negedge clk);
    cyc_i = 1'b1; stb_i = 1'b1; we_i = we; adr_i = a; be_i = be; dat_i = dat;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!ack_o && n < 8);
    if (!ack_o) check(1'b0, "ack_timeout", 32'h0, 32'h1);
    d = dat_o;
    last_ack_cyc = cyc_cnt;
    @(negedge clk);
    cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
  endtask

  task automatic rd(input logic [16:0] a, input bit c, input logic [31:0] expv,
                    input logic [31:0] mask, input string nm, output logic [31:0] d);
    sb_t e;
    e.chk = c; e.expv = expv; e.mask = mask; e.nm = nm;
    sbq.push_back(e);
    bus(1'b0, a, 4'h0, 32'h0, d);
  endtask

  task automatic rdc(input logic [16:0] a, input logic [31:0] expv, input string nm);
    logic [31:0] d;
    rd(a, 1'b1, expv, 32'hFFFF_FFFF, nm, d);
  endtask

  task automatic rdm(input logic [16:0] a, input logic [31:0] expv, input logic [31:0] mask, input string nm);
    logic [31:0] d;
    rd(a, 1'b1, expv, mask, nm, d);
  endtask

  task automatic rdp(input logic [16:0] a, output logic [31:0] d);
    rd(a, 1'b0, 32'h0, 32'h0, "poll", d);
  endtask

  task automatic wr(input logic [16:0] a, input logic [3:0] be, input logic [31:0] dat);
    logic [31:0] d;
    bus(1'b1, a, be, dat, d);
  endtask

  task automatic regs_zero(input string pfx);
    rdc(17'h000, 32'h0, {pfx, "_ctrl"});
    rdc(17'h004, 32'h0, {pfx, "_status"});
    for (int ch = 0; ch < NUM_CH; ch++) rdc(17'(16 + 4*ch), 32'h0, {pfx, "_chcfg"});
  endtask

  task automatic wait_duty(input logic [16:0] a, input logic [7:0] v, input int maxr, input string nm);
    logic [31:0] d;
    bit          hit;
    hit = 1'b0;
    d   = '0;
    for (int k = 0; k < maxr && !hit; k++) begin
      rdp(a, d);
      if (d[15:8] == v) hit = 1'b1;
    end
    check(hit, nm, {24'h0, d[15:8]}, {24'h0, v});
  endtask

  // Follows DUTY_CUR of one channel; each step must be +/-1 and 1024 clocks apart.
  task automatic track(input int ch, input logic [7:0] start, input bit up, input int nsteps,
                       input int maxr, input string nm);
    logic [31:0] d, smask, sexp;
    logic [7:0]  last, expv;
    logic [16:0] a;
    int          nchg, tprev, dt;
    a = 17'(16 + 4*ch);
    last = start; nchg = 0; tprev = 0;
    smask = (32'h1 << (16 + ch)) | (32'h1 << ch);
    sexp  = 32'h1 << ch;
    for (int k = 0; k < maxr && nchg < nsteps; k++) begin
      rdp(a, d);
      if (d[15:8] != last) begin
        nchg++;
        expv = up ? 8'(start + nchg) : 8'(start - nchg);
        check(d[15:8] == expv, {nm, "_value"}, {24'h0, d[15:8]}, {24'h0, expv});
        if (nchg > 1) begin
          dt = last_ack_cyc - tprev;
          check(dt >= 1021 && dt <= 1027, {nm, "_interval"}, 32'(dt), 32'd1024);
        end
        tprev = last_ack_cyc;
        last  = d[15:8];
        if (nchg < nsteps) rdm(17'h004, sexp, smask, {nm, "_busy_not_done"});
      end
    end
    check(nchg == nsteps, {nm, "_steps"}, 32'(nchg), 32'(nsteps));
  endtask

  task automatic count_pwm(input int n);
    for (int ch = 0; ch < NUM_CH; ch++) pwm_cnt[ch] = 0;
    repeat (n) begin
      @(negedge clk);
      for (int ch = 0; ch < NUM_CH; ch++) if (pwm_o[ch]) pwm_cnt[ch]++;
    end
  endtask

  initial begin : watchdog
    #800000;
    $display("FAIL watchdog: simulation did not complete, checks so far %0d", n_checks);
    $fatal(1);
  end

  initial begin : stim
    int cE, tot;
    bit seen;
    sb_t e;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    regs_zero("por");
    rdc(17'h3F0, DEF, "undef_3f0");
    rdc(17'h008, DEF, "undef_008");
    rdc(17'h020, DEF, "undef_ch4");

    // Static PWM: ch0 duty 64, ch2 duty 255, jumps at first period end
    wr(17'h010, 4'b0111, 32'h0000_0040);
    wr(17'h018, 4'b0111, 32'h0000_00FF);
    wr(17'h000, 4'b0011, 32'h0000_0001);
    rdc(17'h004, 32'h0000_0005, "busy_before_period");
    repeat (300) @(negedge clk);
    rdc(17'h004, 32'h0005_0000, "done_after_period");
    rdc(17'h010, 32'h0000_4040, "ch0_cfg_after_jump");
    count_pwm(256);
    check(pwm_cnt[0] == 64,  "pwm0_high_count", 32'(pwm_cnt[0]), 32'd64);
    check(pwm_cnt[1] == 0,   "pwm1_duty0_low",  32'(pwm_cnt[1]), 32'd0);
    check(pwm_cnt[2] == 255, "pwm2_duty255",    32'(pwm_cnt[2]), 32'd255);
    wr(17'h004, 4'b0100, 32'h0005_0000);
    rdc(17'h004, 32'h0, "w1c_clear");

    // Fade up ch1 0->4, interval 2, prescale 1
    wr(17'h014, 4'b0111, 32'h0002_0004);
    wr(17'h000, 4'b0011, 32'h0000_0101);
    track(1, 8'd0, 1'b1, 4, 4000, "fade_up");
    rdc(17'h004, 32'h0002_0000, "fade_up_done");
    rdc(17'h014, 32'h0002_0404, "fade_up_cfg");

    // Reverse mid-fade: heading to 10 from 3, retarget to 0
    wr(17'h004, 4'b0100, 32'h0002_0000);
    wr(17'h014, 4'b0111, 32'h0000_0000);
    wait_duty(17'h014, 8'd0, 600, "jump_to_0");
    wr(17'h004, 4'b0100, 32'h0002_0000);
    wr(17'h014, 4'b0111, 32'h0002_000A);
    wait_duty(17'h014, 8'd3, 2500, "reach_3");
    wr(17'h014, 4'b0001, 32'h0000_0000);
    track(1, 8'd3, 1'b0, 3, 2500, "reverse");
    rdc(17'h004, 32'h0002_0000, "reverse_done");
    wr(17'h004, 4'b0100, 32'h0001_0000 << 1);
    rdc(17'h004, 32'h0, "reverse_w1c");

    // Byte lanes: only INTERVAL lane enabled
    wr(17'h010, 4'b0100, 32'hFFFF_FFFF);
    rdc(17'h010, 32'h00FF_4040, "byte_lane_interval_only");

    // EN off mid-fade freezes duty and silences outputs
    wr(17'h018, 4'b0111, 32'h0001_0000);
    wait_duty(17'h018, 8'd253, 1500, "ch2_fade_down");
    wr(17'h000, 4'b0011, 32'h0000_0100);
    repeat (4) @(negedge clk);
    count_pwm(600);
    tot = 0;
    for (int ch = 0; ch < NUM_CH; ch++) tot += pwm_cnt[ch];
    check(tot == 0, "en_off_pwm_low", 32'(tot), 32'd0);
    rdc(17'h018, 32'h0001_FD00, "en_off_duty_hold");
    rdc(17'h000, 32'h0000_0100, "ctrl_readback");

    // W1C on the very edge DONE[3] sets: re-enable restarts CNT at 0, set lands 256 edges later
    wr(17'h01C, 4'b0111, 32'h0000_0001);
    wr(17'h000, 4'b0011, 32'h0000_0001);
    cE = last_ack_cyc;
    while (cyc_cnt < cE + 254) @(negedge clk);
    wr(17'h004, 4'b0100, 32'h0008_0000);
    rdm(17'h004, 32'h0008_0000, 32'h0008_0008, "w1c_race_set_wins");
    wr(17'h004, 4'b0100, 32'h0008_0000);
    rdm(17'h004, 32'h0, 32'h0008_0000, "w1c_after_race");
    rdc(17'h01C, 32'h0000_0101, "ch3_cfg");

    // Async reset while ACK is high
    seen = 1'b0;
    for (int k = 0; k < 600 && !seen; k++) begin
      @(negedge clk);
      if (pwm_o[0]) seen = 1'b1;
    end
    check(seen, "pwm0_active_before_reset", {31'b0, seen}, 32'h1);
    e.chk = 1'b0; e.expv = '0; e.mask = '0; e.nm = "lost";
    sbq.push_back(e);
    @(negedge clk);
    cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b0; adr_i = 17'h000;
    @(posedge clk); #1;
    check(ack_o == 1'b1, "ack_before_reset", {31'b0, ack_o}, 32'h1);
    #1 rst_n = 1'b0;
    #1;
    check(ack_o == 1'b0, "ack_dropped_on_reset", {31'b0, ack_o}, 32'h0);
    check(pwm_o == '0, "pwm_low_on_reset", {28'h0, pwm_o}, 32'h0);
    @(negedge clk);
    cyc_i = 1'b0; stb_i = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    regs_zero("post_reset");
    rdc(17'h3F0, DEF, "undef_after_reset");

    repeat (3) @(negedge clk);
    check(sbq.size() == 0, "scoreboard_drained", 32'(sbq.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
